// File: rtl/ula_pkg.sv
// ula_pkg: shared width, arithmetic opcodes and signed-overflow helper for the ULA datapath
package ula_pkg;
  localparam int ULA_WIDTH = 6;
  typedef enum logic [3:0] {
    ADD  = 4'b0000,
    SUB  = 4'b0001,
    RSUB = 4'b0010,
    INCA = 4'b0011,
    DECA = 4'b0100,
    INCB = 4'b0101,
    DECB = 4'b0110,
    NEGA = 4'b0111
  } ula_arith_op_e;
  // Sign bits of the two adder inputs (after any inversion) and of the sum.
  function automatic logic signed_ovf(input logic xs, input logic ys, input logic rs);
    return (xs == ys) && (rs != xs);
  endfunction
endpackage

// File: rtl/ula_addsub.sv
// ula_addsub: combinational adder x + (inv ? ~y : y) + cin with signed overflow
// ports: x_i, y_i operands; inv_i inverts y; cin_i carry-in; sum_o truncated sum; ovf_o signed overflow
module ula_addsub
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             inv_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             ovf_o
);
  logic [WIDTH-1:0] y_eff;
  assign y_eff = inv_i ? ~y_i : y_i;
  assign sum_o = x_i + y_eff + WIDTH'(cin_i);
  assign ovf_o = signed_ovf(x_i[WIDTH-1], y_eff[WIDTH-1], sum_o[WIDTH-1]);
endmodule

// File: rtl/ula_aritmetico.sv
// ula_aritmetico: registered 6-bit arithmetic unit, eight two's-complement ops selected by Sel
// ports: Clk, Reset (async active-low), A, B, Sel in; O, Overflow, Zero registered out
module ula_aritmetico
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Sel,
  output logic [WIDTH-1:0] O,
  output logic             Overflow,
  output logic             Zero
);
  ula_arith_op_e    op;
  logic [WIDTH-1:0] x, y, sum, o_d, o_q;
  logic             inv, add_ovf, ovf_d, ovf_q, zero_q;
  assign op = ula_arith_op_e'(Sel);
  // Every op is x + (y or ~y) + cin; subtraction/decrement/negate use ~y + 1.
  always_comb begin
    x   = (op == RSUB || op == INCB || op == DECB) ? B : (op == NEGA) ? '0 : A;
    y   = (op == ADD || op == SUB) ? B : (op == RSUB || op == NEGA) ? A : WIDTH'(1);
    inv = op == SUB || op == RSUB || op == DECA || op == DECB || op == NEGA;
  end
  ula_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x_i  (x),
    .y_i  (y),
    .inv_i(inv),
    .cin_i(inv),
    .sum_o(sum),
    .ovf_o(add_ovf)
  );
  assign o_d   = Sel[3] ? '0 : sum;
  assign ovf_d = !Sel[3] && add_ovf;
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      o_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      o_q    <= o_d;
      ovf_q  <= ovf_d;
      zero_q <= o_d == '0;
    end
  end
  assign O        = o_q;
  assign Overflow = ovf_q;
  assign Zero     = zero_q;
endmodule

// File: tb/tb_ula_aritmetico.sv
// tb_ula_aritmetico: integer reference model with per-cycle compare plus literal spot checks
module tb_ula_aritmetico;
  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] A = '0, B = '0;
  logic [3:0] Sel = '0;
  logic [5:0] O;
  logic       Overflow, Zero;
  logic [5:0] exp_o = '0;
  logic       exp_v = 1'b0, exp_z = 1'b1;
  logic       chk = 1'b0;
  int         total = 0, bad = 0;
  ula_aritmetico dut (
    .Clk(Clk), .Reset(Reset), .A(A), .B(B), .Sel(Sel),
    .O(O), .Overflow(Overflow), .Zero(Zero)
  );
  always #5 Clk = ~Clk;
  function automatic void model(input logic [5:0] a, input logic [5:0] b, input logic [3:0] s,
                                output logic [5:0] o, output logic v, output logic z);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (s)
      4'd0: r = sa + sb;
      4'd1: r = sa - sb;
      4'd2: r = sb - sa;
      4'd3: r = sa + 1;
      4'd4: r = sa - 1;
      4'd5: r = sb + 1;
      4'd6: r = sb - 1;
      4'd7: r = -sa;
      default: r = 0;
    endcase
    o = r[5:0];
    v = r > 31 || r < -32;
    z = o == 6'd0;
  endfunction
  always @(posedge Clk or negedge Reset)
    if (!Reset) begin
      exp_o = '0; exp_v = 1'b0; exp_z = 1'b1;
    end else model(A, B, Sel, exp_o, exp_v, exp_z);
  always @(negedge Clk)
    if (chk) begin
      total++;
      if (O !== exp_o || Overflow !== exp_v || Zero !== exp_z) begin
        bad++;
        $display("FAIL model A=%0d B=%0d Sel=%b got O=%0d V=%b Z=%b want O=%0d V=%b Z=%b",
                 A, B, Sel, O, Overflow, Zero, exp_o, exp_v, exp_z);
      end
    end
  task automatic check(input string name, input logic [5:0] o, input logic v, input logic z);
    total++;
    if (O !== o || Overflow !== v || Zero !== z) begin
      bad++;
      $display("FAIL %s got O=%0d V=%b Z=%b want O=%0d V=%b Z=%b", name, O, Overflow, Zero, o, v, z);
    end
  endtask
  task automatic step(input logic [5:0] a, input logic [5:0] b, input logic [3:0] s);
    @(negedge Clk);
    A = a; B = b; Sel = s;
    @(posedge Clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge Clk);
    #1 check("reset_hold", 6'd0, 1'b0, 1'b1);
    A = 6'd20; B = 6'd10; Sel = 4'b0000;
    @(negedge Clk);
    Reset = 1'b1;
    chk = 1'b1;
    @(posedge Clk);
    #1 check("after_release", 6'd30, 1'b0, 1'b0);
    #1 Reset = 1'b0;
    #1 check("async_reset", 6'd0, 1'b0, 1'b1);
    @(negedge Clk);
    Reset = 1'b1;
    step(6'd20, 6'd10, 4'b0000); check("add_20_10", 6'd30, 1'b0, 1'b0);
    step(6'd20, 6'd10, 4'b0001); check("sub_20_10", 6'd10, 1'b0, 1'b0);
    step(6'd20, 6'd10, 4'b0010); check("rsub_20_10", 6'd54, 1'b0, 1'b0);
    step(6'd31, 6'd1, 4'b0000); check("add_ovf", 6'd32, 1'b1, 1'b0);
    step(6'd31, 6'd1, 4'b0011); check("inca_ovf", 6'd32, 1'b1, 1'b0);
    step(6'd32, 6'd7, 4'b0111); check("nega_min", 6'd32, 1'b1, 1'b0);
    step(6'd32, 6'd7, 4'b0100); check("deca_min", 6'd31, 1'b1, 1'b0);
    step(6'd63, 6'd0, 4'b0011); check("inca_wrap", 6'd0, 1'b0, 1'b1);
    step(6'd5, 6'd5, 4'b0001); check("sub_zero", 6'd0, 1'b0, 1'b1);
    step(6'd17, 6'd40, 4'b0101); check("incb", 6'd41, 1'b0, 1'b0);
    step(6'd17, 6'd32, 4'b0110); check("decb_min", 6'd31, 1'b1, 1'b0);
    step(6'd33, 6'd22, 4'b1010); check("reserved", 6'd0, 1'b0, 1'b1);
    step(6'd20, 6'd10, 4'b0000); check("lat_before", 6'd30, 1'b0, 1'b0);
    @(negedge Clk);
    Sel = 4'b0001;
    #2 check("lat_hold", 6'd30, 1'b0, 1'b0);
    @(posedge Clk);
    #1 check("lat_after", 6'd10, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++)
      step(6'($urandom), 6'($urandom), 4'($urandom_range(0, 15)));
    @(negedge Clk);
    chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
